// File: rtl/mips32_reg_dump.sv
// Streams a range of register-file words to a valid/ready sink once the core reports HALTED.
// Define MIPS32_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module mips32_reg_dump #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              halted,
  input  logic [AW-1:0]     first_reg,
  input  logic [AW-1:0]     last_reg,
  output logic [AW-1:0]     rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [AW-1:0]     dout_idx,
  output logic              dout_last,
  output logic              busy,
  output logic              err
);

`ifdef MIPS32_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT_HALT, S_READ, S_SEND, S_DONE, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT_HALT, S_READ, S_SEND, S_DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       last_q, last_d;
  logic [DATA_W-1:0]   dout_data_q, dout_data_d;
  logic [AW-1:0]       dout_idx_q, dout_idx_d;
  logic                dout_last_q, dout_last_d;
  logic                err_q, err_d;
`ifdef MIPS32_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    dout_data_d = dout_data_q;
    dout_idx_d  = dout_idx_q;
    dout_last_d = dout_last_q;
    err_d       = 1'b0;
`ifdef MIPS32_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (first_reg > last_reg) begin
            err_d = 1'b1;
          end else begin
            idx_d   = first_reg;
            last_d  = last_reg;
            state_d = halted ? S_READ : S_WAIT_HALT;
`ifdef MIPS32_DUMP_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
      end
      S_WAIT_HALT: begin
        if (halted) state_d = S_READ;
      end
      S_READ: begin
        dout_data_d = rf_rdata;
        dout_idx_d  = idx_q;
`ifdef MIPS32_DUMP_CHECKSUM_EN
        dout_last_d = 1'b0;
`else
        dout_last_d = (idx_q == last_q);
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (dout_ready) begin
`ifdef MIPS32_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ dout_data_q;
`endif
          // idx only advances while below last, so it can never wrap past 31
          if (idx_q == last_q) begin
`ifdef MIPS32_DUMP_CHECKSUM_EN
            dout_data_d = csum_q ^ dout_data_q;
            dout_idx_d  = '0;
            dout_last_d = 1'b1;
            state_d     = S_CSUM;
`else
            state_d     = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_READ;
          end
        end
      end
`ifdef MIPS32_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (dout_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      dout_data_q <= '0;
      dout_idx_q  <= '0;
      dout_last_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef MIPS32_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      dout_data_q <= dout_data_d;
      dout_idx_q  <= dout_idx_d;
      dout_last_q <= dout_last_d;
      err_q       <= err_d;
`ifdef MIPS32_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rf_raddr  = (state_q == S_READ) ? idx_q : '0;
`ifdef MIPS32_DUMP_CHECKSUM_EN
  assign dout_valid = (state_q == S_SEND) || (state_q == S_CSUM);
`else
  assign dout_valid = (state_q == S_SEND);
`endif
  assign dout_data = dout_data_q;
  assign dout_idx  = dout_idx_q;
  assign dout_last = dout_last_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: doc/mips32_reg_dump.md
MIPS32_REG_DUMP -- requirements
Module: mips32_reg_dump

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register word and dout_data width.
REQ-002 Parameter AW, default 5, SHALL set the register index width, giving 32 registers.
REQ-003 clk1  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk1.
REQ-005 start  input  1  SHALL request a dump, sampled only in IDLE.
REQ-006 halted  input  1  SHALL be the processor HALTED flag.
REQ-007 first_reg  input  AW  SHALL give the first register index, sampled with start.
REQ-008 last_reg  input  AW  SHALL give the last register index, sampled with start.
REQ-009 rf_raddr  output  AW  SHALL be the register-file read address.
REQ-010 rf_rdata  input  DATA_W  SHALL be the combinational read data for rf_raddr.
REQ-011 dout_valid  output  1  SHALL mark a valid output beat.
REQ-012 dout_ready  input  1  SHALL be the sink acceptance signal.
REQ-013 dout_data  output  DATA_W  SHALL carry the beat payload.
REQ-014 dout_idx  output  AW  SHALL carry the register index of the beat.
REQ-015 dout_last  output  1  SHALL mark the final beat.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.
REQ-017 err  output  1  SHALL be a one-cycle pulse flagging a rejected request.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_HALT, READ, SEND and DONE; CSUM is added only under REQ-031.
REQ-019 IDLE with start=1 and first_reg>last_reg SHALL pulse err for one cycle and remain in IDLE, emitting no beats.
REQ-020 IDLE with a valid start SHALL latch first_reg and last_reg, load idx=first_reg, and go to READ if halted=1, otherwise to WAIT_HALT.
REQ-021 WAIT_HALT SHALL hold until halted=1, then go to READ; it SHALL have no timeout.
REQ-022 READ SHALL drive rf_raddr=idx for one cycle and register rf_rdata, idx and (idx==last) into dout_data, dout_idx and dout_last, then go to SEND.
REQ-023 SEND SHALL hold dout_valid=1 with dout_data, dout_idx and dout_last stable until dout_valid&&dout_ready.
REQ-024 On acceptance of a non-last beat, SEND SHALL increment idx and return to READ, giving a throughput of one beat per 2 cycles with dout_ready held at 1.
REQ-025 On acceptance of the last beat, SEND SHALL go to DONE.
REQ-026 DONE SHALL last one cycle and then return to IDLE.
REQ-027 Latency: start accepted at edge N with halted=1 SHALL give READ during cycle N+1 and dout_valid=1 during cycle N+2.
REQ-028 first_reg==last_reg SHALL produce exactly one beat with dout_last=1.
REQ-029 idx SHALL never wrap: last_reg=31 ends after index 31; start is ignored while busy=1; a halted deassertion after leaving WAIT_HALT SHALL NOT abort the dump.

Reset
REQ-030 rst=1 SHALL force IDLE (including mid-dump) and zero dout_valid, dout_data, dout_idx, dout_last, busy, err, rf_raddr and idx; the next start SHALL begin a fresh dump.

Configuration
REQ-031 With macro MIPS32_DUMP_CHECKSUM_EN defined, the block SHALL keep a DATA_W running XOR of every accepted data beat, clear it on each accepted start, and follow the last register beat with one CSUM beat (dout_data=XOR, dout_idx=0, dout_last=1); dout_last SHALL then be 0 on register beats.
REQ-032 Without MIPS32_DUMP_CHECKSUM_EN, the CSUM state and checksum register SHALL be absent, and dout_last SHALL mark the last register beat.

Verification
REQ-033 Set R0..R5=0,10,20,25,30,55, halted=1, start with first=0, last=5, ready=1 -> six beats 0,10,20,25,30,55 with idx 0..5, dout_last only on idx 5, done within 14 cycles.
REQ-034 Same setup with ready low for 3 cycles on the beat for idx 2 -> data 20 and idx 2 held stable, then accepted with no beat lost or duplicated.
REQ-035 start with first=7, last=3 -> err high for exactly one cycle, busy stays 0, no dout_valid.
REQ-036 start with halted=0, then halted=1 after 10 cycles -> busy during the wait, first dout_valid 2 cycles after halted rises.
REQ-037 rst asserted during the beat for idx 3 -> all outputs 0 next cycle; a new start with first=0, last=0 -> a single beat of 0 with dout_last=1.
REQ-038 MIPS32_DUMP_CHECKSUM_EN defined, stimulus as REQ-033 -> seventh beat with dout_data=46 and dout_last=1.
